// File: rtl/ibex_fetch_pkg.sv
// rtl/ibex_fetch_pkg.sv - shared types and constants for the instruction fetch master
package ibex_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ibex_fetch_fifo.sv
// rtl/ibex_fetch_fifo.sv - prefetch FIFO with flush; head read straight from storage regs
module ibex_fetch_fifo
  import ibex_fetch_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push_en;
  logic            pop_en;

  assign empty   = (count == '0);
  assign pop_en  = pop && !empty;
  assign push_en = push && ((32'(count) < DEPTH) || pop_en);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '{rdata: 32'd0, pc: BOOT_ADDR};
      end
    end else if (flush) begin
      // Storage is left stale; empty masks it until it is rewritten.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push_en) - CW'(pop_en);
    end
  end

endmodule

// File: rtl/ibex_fetch_master.sv
// rtl/ibex_fetch_master.sv - instruction SRAM req/gnt/rvalid initiator with prefetch FIFO
// Optional FETCH_PERF_CNT_EN adds granted-request and discarded-response counters.
module ibex_fetch_master
  import ibex_fetch_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en_i,
  input  logic              branch_i,
  input  logic [31:0]       branch_addr_i,
  output logic              sram_req,
  input  logic              sram_gnt,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic              sram_rvalid,
  input  logic [31:0]       sram_rdata,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [31:0]       instr_rdata_o,
  output logic [31:0]       instr_pc_o,
  output logic [31:0]       req_cnt_o,
  output logic [31:0]       drop_cnt_o
);

  localparam logic [1:0] IDLE = FETCH_IDLE;
  localparam logic [1:0] REQ  = FETCH_REQ;
  localparam logic [1:0] WAIT = FETCH_WAIT;

  logic [1:0]               state;
  logic [1:0]               state_n;
  logic [31:0]              fetch_pc;
  logic [31:0]              req_pc;
  logic                     outstanding;
  logic                     discard;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     fifo_empty;
  fetch_entry_t             head;
  logic                     gnt;
  logic                     rsp;
  logic                     issue_ok;
  logic                     push;

  assign gnt      = sram_req && sram_gnt;
  assign rsp      = sram_rvalid && outstanding;
  // Counting the in-flight word reserves its FIFO slot, so a push never overruns.
  assign issue_ok = fetch_en_i && ((32'(fifo_count) + 32'(outstanding)) < DEPTH);
  assign push     = rsp && !discard && !branch_i;

  assign sram_req      = (state == REQ);
  assign sram_addr     = sram_req ? fetch_pc[ADDR_W+1:2] : '0;
  assign instr_valid_o = !fifo_empty;
  assign instr_rdata_o = head.rdata;
  assign instr_pc_o    = head.pc;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (issue_ok) state_n = REQ;
      REQ:     if (gnt) state_n = WAIT;
               else if (!fetch_en_i) state_n = IDLE;
      WAIT:    if (rsp) state_n = issue_ok ? REQ : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= BOOT_ADDR;
      req_pc      <= BOOT_ADDR;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      state <= state_n;
      if (gnt) begin
        outstanding <= 1'b1;
        req_pc      <= fetch_pc;
      end else if (rsp) begin
        outstanding <= 1'b0;
      end
      if (branch_i) fetch_pc <= branch_addr_i & ~32'd3;
      else if (gnt) fetch_pc <= fetch_pc + 32'd4;
      // A redirect whose stale word is still in flight marks it for dropping.
      if (rsp) discard <= 1'b0;
      else if (branch_i && (outstanding || gnt)) discard <= 1'b1;
    end
  end

  ibex_fetch_fifo #(
    .DEPTH     (DEPTH),
    .BOOT_ADDR (BOOT_ADDR)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (branch_i),
    .push      (push),
    .push_data ('{rdata: sram_rdata, pc: req_pc}),
    .pop       (instr_valid_o && instr_ready_i),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] req_cnt;
  logic [31:0] drop_cnt;
  logic        drop;

  assign drop = rsp && (discard || branch_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (gnt)  req_cnt  <= req_cnt + 32'd1;
      if (drop) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  assign req_cnt_o  = req_cnt;
  assign drop_cnt_o = drop_cnt;
`else
  assign req_cnt_o  = '0;
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ibex_fetch_master.sv
// tb/tb_ibex_fetch_master.sv - bench for ibex_fetch_master: SRAM responder plus in-order stream model
module tb_ibex_fetch_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        sram_req;
  logic        sram_gnt;
  logic [9:0]  sram_addr;
  logic        sram_rvalid;
  logic [31:0] sram_rdata;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_pc_o;
  logic [31:0] req_cnt_o;
  logic [31:0] drop_cnt_o;

  always #5 clk = ~clk;

  ibex_fetch_master #(
    .DEPTH     (2),
    .ADDR_W    (10),
    .BOOT_ADDR (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en_i    (fetch_en_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .sram_req      (sram_req),
    .sram_gnt      (sram_gnt),
    .sram_addr     (sram_addr),
    .sram_rvalid   (sram_rvalid),
    .sram_rdata    (sram_rdata),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_rdata_o (instr_rdata_o),
    .instr_pc_o    (instr_pc_o),
    .req_cnt_o     (req_cnt_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  // Memory: word[i] = A000_0000 + i, response 1 + extra_lat cycles after the grant.
  logic [9:0] rsp_addr = '0;
  int         rsp_cd = 0;
  int         extra_lat = 0;
  always @(posedge clk) begin
    if (sram_req && sram_gnt) begin
      rsp_cd   <= 1 + extra_lat;
      rsp_addr <= sram_addr;
    end else if (rsp_cd > 0) begin
      rsp_cd <= rsp_cd - 1;
    end
  end
  assign sram_rvalid = (rsp_cd == 1);
  assign sram_rdata  = 32'hA000_0000 + {22'd0, rsp_addr};

  int          tests = 0;
  int          fails = 0;
  int          ndeliv = 0;
  int          ngrant = 0;
  int          exp_drop = 0;
  logic [31:0] exp_pc = 32'h0;
  logic        pend = 1'b0;
  logic        tainted = 1'b0;
  logic        gnt_hit = 1'b0;
  logic [9:0]  last_gnt_addr = '0;
  logic        wrap_seen = 1'b0;
  logic        rand_gnt = 1'b0;
  logic        rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: observe at the falling edge, then re-drive random inputs after the rising edge.
  task automatic cyc();
    logic [31:0] ed;
    @(negedge clk);
    gnt_hit = 1'b0;
    if (!rst_n) begin
      pend = 1'b0; ngrant = 0; exp_drop = 0; exp_pc = 32'h0;
    end else begin
      if (instr_valid_o && instr_ready_i && !branch_i) begin
        ed = 32'hA000_0000 + {22'd0, exp_pc[11:2]};
        chk("stream_pc", instr_pc_o, exp_pc);
        chk("stream_data", instr_rdata_o, ed);
        exp_pc = exp_pc + 32'd4;
        ndeliv++;
      end
      if (sram_rvalid && pend) begin
        if (tainted || branch_i) exp_drop++;
        pend = 1'b0;
      end else if (pend && branch_i) begin
        tainted = 1'b1;
      end
      if (branch_i) exp_pc = branch_addr_i & ~32'd3;
      if (sram_req && sram_gnt) begin
        if (last_gnt_addr == 10'h3FF && sram_addr == 10'h000) wrap_seen = 1'b1;
        pend = 1'b1; tainted = branch_i; ngrant++;
        gnt_hit = 1'b1; last_gnt_addr = sram_addr;
      end
    end
    @(posedge clk);
    #1;
    if (rand_gnt) sram_gnt = 1'($urandom_range(0, 1));
    if (rand_ready) instr_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic run_until_deliv(input int n, input string tag);
    int start;
    start = ndeliv;
    for (int i = 0; i < 400 && (ndeliv - start) < n; i++) cyc();
    chk(tag, 32'(ndeliv - start), 32'(n));
  endtask

  task automatic wait_grant(input logic [9:0] a, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cyc();
      hit = gnt_hit && (last_gnt_addr == a);
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic chk_counters(input string tag);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_req_cnt"}, req_cnt_o, 32'(ngrant));
    chk({tag, "_drop_cnt"}, drop_cnt_o, 32'(exp_drop));
`else
    chk({tag, "_req_cnt"}, req_cnt_o, 32'd0);
    chk({tag, "_drop_cnt"}, drop_cnt_o, 32'd0);
`endif
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; fetch_en_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
    sram_gnt = 1'b0; instr_ready_i = 1'b1;
    cyc(); cyc();
    chk("rst_sram_req", 32'(sram_req), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_rdata", instr_rdata_o, 32'd0);
    chk("rst_pc", instr_pc_o, 32'h0);
    chk_counters("rst");

    // Free-running fetch from boot.
    rst_n = 1'b1; fetch_en_i = 1'b1; sram_gnt = 1'b1;
    run_until_deliv(8, "boot_stream");
    chk_counters("boot");

    // Core stall fills the FIFO, then drains in order and resumes at PC 8.
    instr_ready_i = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) cyc();
    chk("stall_grants", 32'(ngrant), 32'd2);
    chk("stall_req_low", 32'(sram_req), 32'd0);
    chk("stall_valid", 32'(instr_valid_o), 32'd1);
    chk("stall_head_pc", instr_pc_o, 32'h0);
    chk("stall_head_data", instr_rdata_o, 32'hA000_0000);
    instr_ready_i = 1'b1;
    wait_grant(10'd2, "stall_resume_addr");
    run_until_deliv(3, "stall_drain");

    // Redirect in the cycle after the grant for PC 8 drops that word.
    do_reset();
    wait_grant(10'd2, "br_wait_pc8");
    branch_i = 1'b1; branch_addr_i = 32'h0000_0103;
    cyc();
    branch_i = 1'b0;
    run_until_deliv(2, "br_after");
    chk_counters("br");

    // Redirect in REQ before grant switches the address, no drop.
    sram_gnt = 1'b0;
    do_reset();
    for (int i = 0; i < 20 && !sram_req; i++) cyc();
    chk("breq_req", 32'(sram_req), 32'd1);
    chk("breq_addr0", 32'(sram_addr), 32'd0);
    branch_i = 1'b1; branch_addr_i = 32'h0000_0200;
    cyc();
    branch_i = 1'b0;
    chk("breq_req2", 32'(sram_req), 32'd1);
    chk("breq_addr1", 32'(sram_addr), 32'h80);
    sram_gnt = 1'b1;
    run_until_deliv(2, "breq_stream");
    chk("breq_nodrop", drop_cnt_o, 32'd0);

    // Reset while a slow response is in flight; the stray rvalid must be ignored.
    extra_lat = 2;
    do_reset();
    wait_grant(10'd0, "rstw_grant");
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; fetch_en_i = 1'b0; extra_lat = 0;
    for (int i = 0; i < 4; i++) cyc();
    chk("rstw_empty", 32'(instr_valid_o), 32'd0);
    chk("rstw_drop", drop_cnt_o, 32'd0);
    fetch_en_i = 1'b1;
    run_until_deliv(2, "rstw_stream");

    // Word-address wrap at 2^ADDR_W.
    wrap_seen = 1'b0;
    branch_i = 1'b1; branch_addr_i = 32'h0000_0FF8;
    cyc();
    branch_i = 1'b0;
    run_until_deliv(4, "wrap10_stream");
    chk("wrap10_addr", 32'(wrap_seen), 32'd1);

    // 32-bit PC wrap.
    branch_i = 1'b1; branch_addr_i = 32'hFFFF_FFFA;
    cyc();
    branch_i = 1'b0;
    run_until_deliv(4, "wrap32_stream");
    chk_counters("wrap");

    // Random grants, back-pressure, enables and redirects.
    rand_gnt = 1'b1; rand_ready = 1'b1;
    d0 = ndeliv;
    for (int i = 0; i < 3000; i++) begin
      fetch_en_i = ($urandom_range(0, 15) != 0);
      branch_i = ($urandom_range(0, 24) == 0);
      branch_addr_i = $urandom;
      cyc();
    end
    branch_i = 1'b0; fetch_en_i = 1'b1;
    rand_gnt = 1'b0; rand_ready = 1'b0; sram_gnt = 1'b1; instr_ready_i = 1'b1;
    run_until_deliv(4, "rand_tail");
    chk("rand_progress", 32'((ndeliv - d0) > 100), 32'd1);
    chk_counters("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
